// File: rtl/soma_sub_pkg.sv
// Shared types and constants for the signed 4-bit add/subtract sequencer.
package soma_sub_pkg;

    localparam int NBITS_OPND = 4;

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        EXEC   = 2'b10,
        SHOW   = 2'b11
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_ERR = 7'h79;

    function automatic logic [6:0] digit_pattern(input logic [NBITS_OPND-1:0] mag);
        case (mag)
            4'd0:    digit_pattern = SEG_0;
            4'd1:    digit_pattern = SEG_1;
            4'd2:    digit_pattern = SEG_2;
            4'd3:    digit_pattern = SEG_3;
            4'd4:    digit_pattern = SEG_4;
            4'd5:    digit_pattern = SEG_5;
            4'd6:    digit_pattern = SEG_6;
            4'd7:    digit_pattern = SEG_7;
            4'd8:    digit_pattern = SEG_8;
            default: digit_pattern = SEG_ERR;
        endcase
    endfunction

endpackage

// File: rtl/seg7_signed_decoder.sv
// Sign-plus-digit 7-segment decoder for a 4-bit two's-complement value.
module seg7_signed_decoder
    import soma_sub_pkg::*;
(
    input  logic [NBITS_OPND-1:0] i_value,
    input  logic                  i_err,
    output logic [7:0]            o_seg
);

    logic [NBITS_OPND-1:0] w_mag;

    // -8 negates to 4'b1000, which reads correctly as unsigned 8
    always_comb begin
        w_mag = i_value[NBITS_OPND-1] ? (~i_value + 4'd1) : i_value;
        if (i_err) begin
            o_seg = {1'b0, SEG_ERR};
        end else begin
            o_seg = {i_value[NBITS_OPND-1], digit_pattern(w_mag)};
        end
    end

endmodule

// File: rtl/soma_sub_sequencer.sv
// Operand load / execute / show sequencer for the signed 4-bit add/subtract datapath.
// Optional enter debounce filter compiled in with SOMA_SUB_DEBOUNCE_EN (adds DEBOUNCE_CYCLES).
module soma_sub_sequencer
    import soma_sub_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES = 0
`ifdef SOMA_SUB_DEBOUNCE_EN
    , parameter int unsigned DEBOUNCE_CYCLES = 4
`endif
) (
    input  logic                  clk_2,
    input  logic                  reset_n,
    input  logic [NBITS_OPND-1:0] swi_operand,
    input  logic                  swi_op,
    input  logic                  btn_enter,
    output logic [7:0]            seg,
    output logic [7:0]            led,
    output logic                  busy,
    output logic                  overflow
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_prev;
    logic                  w_level;
    logic                  w_enter;
    logic [NBITS_OPND-1:0] r_a;
    logic [NBITS_OPND-1:0] r_b;
    logic [NBITS_OPND-1:0] r_result;
    logic                  r_op;
    logic                  r_overflow;
    logic [31:0]           r_timer;
    logic                  w_timeout;
    logic [NBITS_OPND:0]   w_sum;
    logic [NBITS_OPND-1:0] w_disp_val;
    logic                  w_disp_err;

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= btn_enter;
            r_sync2 <= r_sync1;
            r_prev  <= w_level;
        end
    end

`ifdef SOMA_SUB_DEBOUNCE_EN
    localparam int unsigned DB_LAST = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0;

    logic [31:0] r_db_cnt;
    logic        r_filt;

    // Filtered level flips only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_db_cnt <= '0;
            r_filt   <= 1'b0;
        end else if (r_sync2 == r_filt) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt >= DB_LAST) begin
            r_filt   <= r_sync2;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 32'd1;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    assign w_enter   = w_level & ~r_prev;
    assign w_timeout = (SHOW_CYCLES != 0) && (r_timer == SHOW_CYCLES - 1);
    assign w_sum     = (r_op == OP_SUB) ? ({r_a[NBITS_OPND-1], r_a} - {r_b[NBITS_OPND-1], r_b})
                                        : ({r_a[NBITS_OPND-1], r_a} + {r_b[NBITS_OPND-1], r_b});

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= LOAD_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD_A:  if (w_enter) w_state_nxt = LOAD_B;
            LOAD_B:  if (w_enter) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = SHOW;
            SHOW:    if (w_enter || w_timeout) w_state_nxt = LOAD_A;
            default: w_state_nxt = LOAD_A;
        endcase
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_timer    <= '0;
        end else begin
            case (r_state)
                LOAD_A: if (w_enter) r_a <= swi_operand;
                LOAD_B: if (w_enter) begin
                    r_b  <= swi_operand;
                    r_op <= swi_op;
                end
                EXEC: begin
                    r_result   <= w_sum[NBITS_OPND-1:0];
                    r_overflow <= w_sum[NBITS_OPND] ^ w_sum[NBITS_OPND-1];
                    r_timer    <= '0;
                end
                SHOW: if (r_timer != '1) r_timer <= r_timer + 32'd1;
                default: ;
            endcase
        end
    end

    assign w_disp_val = (r_state == SHOW) ? r_result : swi_operand;
    assign w_disp_err = (r_state == SHOW) && r_overflow;

    seg7_signed_decoder u_dec (
        .i_value (w_disp_val),
        .i_err   (w_disp_err),
        .o_seg   (seg)
    );

    assign led      = {r_result, r_overflow, r_op, r_state};
    assign busy     = (r_state == EXEC);
    assign overflow = r_overflow;

endmodule

// File: tb/tb_soma_sub_sequencer.sv
// Directed scoreboard bench for soma_sub_sequencer: hold-until-enter and auto-timeout instances.
module tb_soma_sub_sequencer;

`ifdef SOMA_SUB_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif
    localparam int PW = DB + 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] swi_operand;
    logic       swi_op;
    logic       btn0, btn1;
    logic [7:0] seg0, led0, seg1, led1;
    logic       busy0, ovf0, busy1, ovf1;

    always #5 clk = ~clk;

    soma_sub_sequencer #(.SHOW_CYCLES(0)) u_dut0 (
        .clk_2(clk), .reset_n(reset_n), .swi_operand(swi_operand), .swi_op(swi_op),
        .btn_enter(btn0), .seg(seg0), .led(led0), .busy(busy0), .overflow(ovf0)
    );

    soma_sub_sequencer #(.SHOW_CYCLES(10)) u_dut1 (
        .clk_2(clk), .reset_n(reset_n), .swi_operand(swi_operand), .swi_op(swi_op),
        .btn_enter(btn1), .seg(seg1), .led(led1), .busy(busy1), .overflow(ovf1)
    );

    typedef struct {
        logic [7:0] seg;
        logic [7:0] led;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   busy_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] pat(input int m);
        case (m)
            0: pat = 7'h3F;  1: pat = 7'h06;  2: pat = 7'h5B;
            3: pat = 7'h4F;  4: pat = 7'h66;  5: pat = 7'h6D;
            6: pat = 7'h7D;  7: pat = 7'h07;  8: pat = 7'h7F;
            default: pat = 7'h00;
        endcase
    endfunction

    task automatic push_expect(input int a, input int b, input bit op);
        int          r;
        logic [31:0] rv;
        int          mag;
        exp_t        e;
        r     = op ? a - b : a + b;
        rv    = r;
        e.ovf = (r > 7) || (r < -8);
        mag   = (r < 0) ? -r : r;
        e.seg = e.ovf ? 8'h79 : {(r < 0), pat(mag)};
        e.led = {rv[3:0], e.ovf, op, 2'b11};
        sb.push_back(e);
    endtask

    task automatic pop_compare(input string tag, input logic [7:0] s, input logic [7:0] l, input logic o);
        exp_t e;
        check({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_seg"}, s, e.seg);
            check({tag, "_led"}, l, e.led);
            check({tag, "_ovf"}, o, e.ovf);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit which);
        for (int i = 0; i < 16; i++) begin
            if (which) btn1 = (i < 8);
            else       btn0 = (i < 8);
            @(negedge clk);
            if (which ? busy1 : busy0) busy_cnt++;
        end
    endtask

    task automatic do_op(input string tag, input int a, input int b, input bit op, input bit ret);
        swi_operand = 4'(a);
        press(0);
        check({tag, "_in_load_b"}, led0[1:0], 2'b01);
        swi_operand = 4'(b);
        swi_op      = op;
        push_expect(a, b, op);
        busy_cnt = 0;
        press(0);
        check({tag, "_busy_cycles"}, busy_cnt, 1);
        swi_operand = ~swi_operand;
        tick(1);
        pop_compare(tag, seg0, led0, ovf0);
        if (ret) begin
            press(0);
            check({tag, "_back_load_a"}, led0[1:0], 2'b00);
        end
    endtask

    // Runs one B-load on the timeout instance; optionally raises enter so its
    // event lands in the same cycle as the timeout.
    task automatic dut1_show_run(input string tag, input bit coincide);
        int  n_show = 0;
        btn1 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (led1[1:0] == 2'b11) begin
                n_show++;
                if (n_show == 1) pop_compare(tag, seg1, led1, ovf1);
            end
            if (k == PW) btn1 = 1'b0;
            if (coincide && k == 11) btn1 = 1'b1;
        end
        check({tag, "_show_cycles"}, n_show, 10);
        check({tag, "_final_state"}, led1[1:0], 2'b00);
        btn1 = 1'b0;
        tick(16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int         changes;
        logic [1:0] prev;

        reset_n = 1'b0; swi_operand = 4'h0; swi_op = 1'b0; btn0 = 1'b0; btn1 = 1'b0;
        tick(3);
        check("rst_seg", seg0, 8'h3F);
        check("rst_led", led0, 8'h00);
        check("rst_busy", busy0, 1'b0);
        check("rst_ovf", ovf0, 1'b0);
        check("rst_seg1", seg1, 8'h3F);
        reset_n = 1'b1;
        tick(2);

        do_op("add_3_2", 3, 2, 1'b0, 1'b1);
        do_op("sub_2_5", 2, 5, 1'b1, 1'b1);
        do_op("add_7_1", 7, 1, 1'b0, 1'b0);

        swi_operand = 4'h0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_show_seg", seg0, 8'h3F);
        check("rst_show_led", led0, 8'h00);
        check("rst_show_ovf", ovf0, 1'b0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        do_op("add_m4_m4", -4, -4, 1'b0, 1'b1);

        swi_operand = 4'd6;
        btn0 = 1'b1;
        changes = 0;
        prev = led0[1:0];
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (led0[1:0] != prev) changes++;
            prev = led0[1:0];
            if (i == 10) swi_operand = 4'hE;
        end
        check("hold_transitions", changes, 1);
        check("hold_state", led0[1:0], 2'b01);
        btn0 = 1'b0;
        tick(12);
        swi_operand = 4'd1; swi_op = 1'b0;
        push_expect(6, 1, 1'b0);
        busy_cnt = 0;
        press(0);
        check("hold_busy_cycles", busy_cnt, 1);
        pop_compare("hold_a6_b1", seg0, led0, ovf0);
        press(0);

        swi_operand = 4'd5;
        press(0);
        check("ldb_state", led0[1:0], 2'b01);
        check("ldb_live_seg", seg0, 8'h6D);
        swi_operand = 4'h0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_ldb_seg", seg0, 8'h3F);
        check("rst_ldb_led", led0, 8'h00);
        check("rst_ldb_busy", busy0, 1'b0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        do_op("sub_m8_1", -8, 1, 1'b1, 1'b1);

`ifdef SOMA_SUB_DEBOUNCE_EN
        btn0 = 1'b1;
        tick(2);
        btn0 = 1'b0;
        tick(15);
        check("glitch_no_event", led0[1:0], 2'b00);
`endif

        swi_operand = 4'd2;
        press(1);
        check("t1_in_load_b", led1[1:0], 2'b01);
        swi_operand = 4'd3; swi_op = 1'b0;
        push_expect(2, 3, 1'b0);
        dut1_show_run("t1_timeout", 1'b0);

        swi_operand = 4'hD;
        press(1);
        check("t2_in_load_b", led1[1:0], 2'b01);
        swi_operand = 4'd4; swi_op = 1'b1;
        push_expect(-3, 4, 1'b1);
        dut1_show_run("t2_coincide", 1'b1);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
